// File: rtl/wb_command_master.sv
// Wishbone B4 pipelined initiator: one command in, one bus access (with retry and
// timeout handling), one response out. Only a single transaction is ever in flight.
module wb_command_master #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [31:0]              i_cmd_write_data,
  input  logic [3:0]               i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
  output logic [31:0]              o_wb_dat,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty,
  input  logic [31:0]              i_wb_dat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_GAP,
    S_RESPOND
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  state_t      state;
  logic [15:0] timeout_count;
  logic [3:0]  retry_count;

  // The strobe counts as taken on any non-stalled REQUEST cycle; only then may it terminate.
  logic accepted;
  logic terminated;
  logic time_up;

  assign accepted   = (state == S_WAIT) || ((state == S_REQUEST) && !i_wb_stall);
  assign terminated = accepted && (i_wb_ack || i_wb_err || i_wb_rty);
  assign time_up    = (timeout_count == TIMEOUT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      timeout_count   <= '0;
      retry_count     <= '0;
      o_cmd_ready     <= 1'b0;
      o_rsp_valid     <= 1'b0;
      o_rsp_read_data <= '0;
      o_rsp_status    <= '0;
      o_wb_cyc        <= 1'b0;
      o_wb_stb        <= 1'b0;
      o_wb_we         <= 1'b0;
      o_wb_adr        <= '0;
      o_wb_dat        <= '0;
      o_wb_sel        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_cmd_ready <= 1'b1;
          if (i_cmd_valid && o_cmd_ready) begin
            o_wb_we       <= i_cmd_write;
            o_wb_adr      <= i_cmd_address;
            o_wb_dat      <= i_cmd_write_data;
            o_wb_sel      <= i_cmd_strobe;
            o_wb_cyc      <= 1'b1;
            o_wb_stb      <= 1'b1;
            o_cmd_ready   <= 1'b0;
            timeout_count <= '0;
            retry_count   <= '0;
            state         <= S_REQUEST;
          end
        end

        S_REQUEST, S_WAIT: begin
          if (terminated) begin
            o_wb_stb <= 1'b0;
            if (i_wb_ack) begin
              o_wb_cyc        <= 1'b0;
              o_rsp_valid     <= 1'b1;
              o_rsp_status    <= ST_OK;
              o_rsp_read_data <= o_wb_we ? 32'h0 : i_wb_dat;
              state           <= S_RESPOND;
            end else if (i_wb_err) begin
              o_wb_cyc        <= 1'b0;
              o_rsp_valid     <= 1'b1;
              o_rsp_status    <= ST_ERR;
              o_rsp_read_data <= '0;
              state           <= S_RESPOND;
            end else if (retry_count < RETRY_LIMIT) begin
              o_wb_cyc    <= 1'b0;
              retry_count <= retry_count + 4'd1;
              state       <= S_GAP;
            end else begin
              o_wb_cyc        <= 1'b0;
              o_rsp_valid     <= 1'b1;
              o_rsp_status    <= ST_RETRY;
              o_rsp_read_data <= '0;
              state           <= S_RESPOND;
            end
          end else if (time_up) begin
            o_wb_cyc        <= 1'b0;
            o_wb_stb        <= 1'b0;
            o_rsp_valid     <= 1'b1;
            o_rsp_status    <= ST_TIMEOUT;
            o_rsp_read_data <= '0;
            state           <= S_RESPOND;
          end else begin
            timeout_count <= timeout_count + 16'd1;
            if (state == S_REQUEST && !i_wb_stall) begin
              o_wb_stb <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end

        // Bus fields are still latched, so the reissue is identical to the first attempt.
        S_GAP: begin
          o_wb_cyc      <= 1'b1;
          o_wb_stb      <= 1'b1;
          timeout_count <= '0;
          state         <= S_REQUEST;
        end

        S_RESPOND: begin
          if (i_rsp_ready) begin
            o_rsp_valid   <= 1'b0;
            o_cmd_ready   <= 1'b1;
            timeout_count <= '0;
            retry_count   <= '0;
            state         <= S_IDLE;
          end
        end

        default: begin
          o_wb_cyc    <= 1'b0;
          o_wb_stb    <= 1'b0;
          o_rsp_valid <= 1'b0;
          o_cmd_ready <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_command_master.sv
// Bench for wb_command_master: a scripted Wishbone responder, a directed table, random
// transactions predicted by a transaction-level model, and a mid-cycle reset sequence.
module tb_wb_command_master;

  localparam int AW = 32;
  localparam int TO = 8;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_address;
  logic [31:0]   i_cmd_write_data;
  logic [3:0]    i_cmd_strobe;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_read_data;
  logic [1:0]    o_rsp_status;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty;
  logic [31:0]   i_wb_dat;

  always #5 clk = ~clk;

  wb_command_master #(
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MR)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_write     (i_cmd_write),
    .i_cmd_address   (i_cmd_address),
    .i_cmd_write_data(i_cmd_write_data),
    .i_cmd_strobe    (i_cmd_strobe),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_read_data (o_rsp_read_data),
    .o_rsp_status    (o_rsp_status),
    .o_wb_cyc        (o_wb_cyc),
    .o_wb_stb        (o_wb_stb),
    .o_wb_we         (o_wb_we),
    .o_wb_adr        (o_wb_adr),
    .o_wb_dat        (o_wb_dat),
    .o_wb_sel        (o_wb_sel),
    .i_wb_stall      (i_wb_stall),
    .i_wb_ack        (i_wb_ack),
    .i_wb_err        (i_wb_err),
    .i_wb_rty        (i_wb_rty),
    .i_wb_dat        (i_wb_dat)
  );

  // One transaction: command, responder script, and expected outcome.
  // Responder: stall cycles per issue, cycles from acceptance to termination, number of
  // leading rty answers, then the final {rty,err,ack} mask (0 = never answers).
  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    int          lat;
    int          nrty;
    logic [2:0]  mask;
    logic [31:0] rdata;
    int          rdly;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    int          exp_issues;
  } vec_t;

  vec_t cur;
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] adr, input logic [31:0] wdata,
                              input logic [3:0] sel, input int stall, input int lat,
                              input int nrty, input logic [2:0] mask, input logic [31:0] rdata,
                              input int rdly, input logic [1:0] est, input logic [31:0] edata,
                              input int eiss);
    vec_t v;
    v.wr = wr; v.adr = adr; v.wdata = wdata; v.sel = sel;
    v.stall = stall; v.lat = lat; v.nrty = nrty; v.mask = mask; v.rdata = rdata;
    v.rdly = rdly; v.exp_status = est; v.exp_data = edata; v.exp_issues = eiss;
    return v;
  endfunction

  // Transaction-level prediction: walk the attempts, each taking stall+1+lat bus cycles
  // unless the timeout budget runs out first; rty costs one idle gap until retries run out.
  task automatic model(input vec_t v, output logic [1:0] st, output logic [31:0] rd,
                       output int iss, output int total, output int cycs, output int stbs);
    int d;
    st = 2'b00; rd = '0; iss = 0; total = 0; cycs = 0; stbs = 0;
    for (int k = 0; k < 20; k++) begin
      iss++;
      d = v.stall + 1 + v.lat;
      if ((iss > v.nrty && v.mask == 3'b000) || d > TO) begin
        total += TO; cycs += TO;
        stbs  += (v.stall + 1 < TO) ? v.stall + 1 : TO;
        st = 2'b10;
        break;
      end
      total += d; cycs += d; stbs += v.stall + 1;
      if (iss <= v.nrty) begin
        if (iss - 1 < MR) begin
          total += 1;
          continue;
        end
        st = 2'b11;
        break;
      end
      if (v.mask[0]) begin
        st = 2'b00;
        rd = v.wr ? 32'h0 : v.rdata;
      end else begin
        st = 2'b01;
      end
      break;
    end
  endtask

  // Scripted responder, driven on the falling edge.
  int r_stall_cnt = 0, r_wait_cnt = 0, r_iss = 0;
  bit r_acc = 1'b0;

  task automatic drive_term();
    if (r_iss < cur.nrty) begin
      i_wb_rty = 1'b1;
    end else begin
      {i_wb_rty, i_wb_err, i_wb_ack} = cur.mask;
      if (cur.mask[0]) i_wb_dat = cur.rdata;
    end
    r_iss++;
  endtask

  always @(negedge clk) begin
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rty = 1'b0; i_wb_stall = 1'b0;
    i_wb_dat = $urandom;
    if (o_cmd_ready) r_iss = 0;
    if (!o_wb_cyc) begin
      r_stall_cnt = 0; r_acc = 1'b0; r_wait_cnt = 0;
    end else if (o_wb_stb && !r_acc) begin
      if (r_stall_cnt < cur.stall) begin
        i_wb_stall = 1'b1;
        {i_wb_rty, i_wb_err, i_wb_ack} = 3'($urandom_range(0, 7));  // must be ignored
        r_stall_cnt++;
      end else begin
        r_acc = 1'b1; r_wait_cnt = 0;
        if (cur.lat == 0) drive_term();
      end
    end else if (r_acc) begin
      r_wait_cnt++;
      if (r_wait_cnt == cur.lat) drive_term();
    end
  end

  // Bus monitor: cycle/strobe counts and protocol rule violations.
  int mon_cyc = 0, mon_stb = 0, mon_iss = 0, proto_err = 0;
  bit prev_stb = 1'b0;

  always @(negedge clk) begin
    if (o_wb_cyc) mon_cyc++;
    if (o_wb_stb) begin
      mon_stb++;
      if (!prev_stb) mon_iss++;
      if (!i_rst && (o_wb_adr !== cur.adr || o_wb_dat !== cur.wdata ||
                     o_wb_sel !== cur.sel || o_wb_we !== cur.wr || !o_wb_cyc)) proto_err++;
    end
    if (o_wb_cyc && (o_cmd_ready || o_rsp_valid)) proto_err++;
    if (o_rsp_valid && o_cmd_ready) proto_err++;
    prev_stb = o_wb_stb;
  end

  task automatic run_vec(input vec_t v, input bit use_table);
    logic [1:0]  m_st;
    logic [31:0] m_rd, first_rd;
    logic [1:0]  first_st;
    int m_iss, m_total, m_cyc, m_stb;
    int c0, s0, i0, p0, n, hold_bad;
    cur = v;
    model(v, m_st, m_rd, m_iss, m_total, m_cyc, m_stb);
    if (!use_table) begin
      cur.exp_status = m_st; cur.exp_data = m_rd; cur.exp_issues = m_iss;
    end
    n = 0;
    while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1; i_cmd_write = v.wr; i_cmd_address = v.adr;
    i_cmd_write_data = v.wdata; i_cmd_strobe = v.sel;
    c0 = mon_cyc; s0 = mon_stb; i0 = mon_iss; p0 = proto_err;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    n = 0;
    while (!o_rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
    chk("latency", 32'(n), 32'(m_total));
    chk("status", 32'(o_rsp_status), 32'(cur.exp_status));
    chk("read_data", o_rsp_read_data, cur.exp_data);
    chk("issues", 32'(mon_iss - i0), 32'(cur.exp_issues));
    chk("cyc_cycles", 32'(mon_cyc - c0), 32'(m_cyc));
    chk("stb_cycles", 32'(mon_stb - s0), 32'(m_stb));
    first_rd = o_rsp_read_data; first_st = o_rsp_status; hold_bad = 0;
    for (int r = 0; r < v.rdly; r++) begin
      @(negedge clk);
      if (!o_rsp_valid || o_cmd_ready || o_rsp_read_data !== first_rd ||
          o_rsp_status !== first_st) hold_bad++;
    end
    chk("rsp_hold", 32'(hold_bad), 32'd0);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk("rsp_consumed", {30'd0, o_rsp_valid, o_cmd_ready}, 32'd1);
    chk("protocol", 32'(proto_err - p0), 32'd0);
    n_vec++;
    $display("vec %0d: %s adr=%h status=%0d data=%h issues=%0d latency=%0d",
             n_vec, v.wr ? "WR" : "RD", v.adr, o_rsp_status, first_rd, mon_iss - i0, n);
  endtask

  vec_t tbl[14];
  logic [2:0] masks[7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    vec_t v;
    int   n, bad;
    //          wr adr     wdata          sel  stl lat rty mask    rdata          rdly st     data          iss
    tbl[0]  = mk(1, 32'h00, 32'h0001C200, 4'hF, 2, 1, 0, 3'b001, 32'h0,        0, 2'b00, 32'h0,        1);
    tbl[1]  = mk(0, 32'h04, 32'h0,        4'hF, 0, 0, 0, 3'b001, 32'h41,       5, 2'b00, 32'h41,       1);
    tbl[2]  = mk(1, 32'h10, 32'hCAFE0001, 4'hF, 0, 1, 0, 3'b010, 32'h0,        0, 2'b01, 32'h0,        1);
    tbl[3]  = mk(1, 32'h10, 32'h12345678, 4'h3, 1, 0, 0, 3'b011, 32'h0,        1, 2'b00, 32'h0,        1);
    tbl[4]  = mk(0, 32'h08, 32'h0,        4'hF, 0, 1, 2, 3'b001, 32'h55,       0, 2'b00, 32'h55,       3);
    tbl[5]  = mk(0, 32'h08, 32'h0,        4'hF, 1, 0, 4, 3'b001, 32'h66,       0, 2'b11, 32'h0,        4);
    tbl[6]  = mk(0, 32'h0C, 32'h0,        4'hF, 0, 0, 0, 3'b000, 32'h77,       2, 2'b10, 32'h0,        1);
    tbl[7]  = mk(0, 32'h04, 32'h0,        4'hF, 1, 2, 0, 3'b001, 32'h1234,     0, 2'b00, 32'h1234,     1);
    tbl[8]  = mk(0, 32'h20, 32'h0,        4'hF, 0, 7, 0, 3'b001, 32'hA5A5A5A5, 0, 2'b00, 32'hA5A5A5A5, 1);
    tbl[9]  = mk(0, 32'h20, 32'h0,        4'hF, 0, 8, 0, 3'b001, 32'h5A,       0, 2'b10, 32'h0,        1);
    tbl[10] = mk(0, 32'h24, 32'h0,        4'hF, 0, 1, 0, 3'b110, 32'h99,       0, 2'b01, 32'h0,        1);
    tbl[11] = mk(0, 32'h28, 32'h0,        4'hF, 2, 0, 0, 3'b101, 32'h7,        0, 2'b00, 32'h7,        1);
    tbl[12] = mk(1, 32'h2C, 32'hFFFF0000, 4'h8, 8, 0, 0, 3'b001, 32'h0,        0, 2'b10, 32'h0,        1);
    tbl[13] = mk(0, 32'h30, 32'h0,        4'hF, 0, 0, 3, 3'b010, 32'h3,        1, 2'b01, 32'h0,        4);

    i_rst = 1'b1; i_cmd_valid = 1'b0; i_rsp_ready = 1'b0; i_cmd_write = 1'b0;
    i_cmd_address = '0; i_cmd_write_data = '0; i_cmd_strobe = '0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {o_cmd_ready, o_rsp_valid, o_wb_cyc, o_wb_stb, o_wb_we,
                          o_rsp_status, o_wb_sel}, 32'd0);
    chk("reset_data", o_rsp_read_data | o_wb_dat | o_wb_adr, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(o_cmd_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], 1'b1);

    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.adr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.sel = 4'($urandom_range(0, 15));
      v.stall = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3);
      v.lat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 4);
      v.nrty = $urandom_range(0, 5);
      v.mask = masks[$urandom_range(0, 6)];
      v.rdata = $urandom;
      v.rdly = $urandom_range(0, 3);
      run_vec(v, 1'b0);
    end

    // Reset while the responder leaves the master waiting: bus drops at once, no response.
    cur = mk(0, 32'h40, 32'h0, 4'hF, 0, 0, 0, 3'b000, 32'h0, 0, 2'b10, 32'h0, 1);
    n = 0;
    while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_address = 32'h40;
    i_cmd_write_data = 32'h0; i_cmd_strobe = 4'hF;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_cyc_before_reset", 32'(o_wb_cyc), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("reset_mid_wait", {o_wb_cyc, o_wb_stb, o_rsp_valid, o_cmd_ready}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_rsp_valid || o_wb_cyc) bad++;
    end
    chk("no_rsp_after_reset", 32'(bad), 32'd0);
    chk("ready_after_mid_reset", 32'(o_cmd_ready), 32'd1);
    n_vec++;
    $display("vec %0d: RD adr=00000040 aborted by reset", n_vec);
    run_vec(mk(0, 32'h44, 32'h0, 4'hF, 0, 1, 0, 3'b001, 32'hBEEF, 0, 2'b00, 32'hBEEF, 1), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
